// File: rtl/btn_repeat_ctrl.sv
// Debounced button with press/release edge pulses and hold-to-repeat move pulses.
// One instance per button; all outputs are registered in the clk domain.
module btn_repeat_ctrl #(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 30000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sync,
  input  logic enable,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic move_pulse
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int STAB_W  = $clog2(STABLE_CYCLES);
  localparam int REP_W   = $clog2(REP_MAX);

  localparam logic [STAB_W-1:0] STAB_TERM   = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [REP_W-1:0]  DELAY_TERM  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  PERIOD_TERM = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [STAB_W-1:0] stab_cnt;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
  logic              press_nxt, release_nxt, move_nxt;
  logic              mismatch, flip, rise, fall;

  // The level flips on the edge that completes the stability window, so the
  // edge pulses are computed from that same edge and appear with the new level.
  assign mismatch = (btn_sync != btn_level);
  assign flip     = mismatch && (stab_cnt == STAB_TERM);
  assign rise     = flip && btn_sync;
  assign fall     = flip && !btn_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_level <= 1'b0;
      stab_cnt  <= '0;
    end else if (!mismatch) begin
      stab_cnt  <= '0;
    end else if (flip) begin
      btn_level <= btn_sync;
      stab_cnt  <= '0;
    end else begin
      stab_cnt  <= stab_cnt + STAB_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    press_nxt   = 1'b0;
    move_nxt    = 1'b0;
    release_nxt = fall;
    // A release beats a coinciding terminal count; disable parks the FSM.
    if (fall || !enable) begin
      state_nxt   = IDLE;
      rep_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt   = DELAY;
            rep_cnt_nxt = '0;
            press_nxt   = 1'b1;
            move_nxt    = 1'b1;
          end
        end
        DELAY: begin
          if (rep_cnt == DELAY_TERM) begin
            state_nxt   = REPEAT;
            rep_cnt_nxt = '0;
            move_nxt    = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt == PERIOD_TERM) begin
            rep_cnt_nxt = '0;
            move_nxt    = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      move_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      rep_cnt       <= rep_cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      move_pulse    <= move_nxt;
    end
  end

endmodule

// File: doc/btn_repeat_ctrl.md
Name: btn_repeat_ctrl

Overview:
- Sits directly downstream of the button synchronizer stage; consumes its synchronized button level.
- Adds a stability-count debounce filter.
- Produces single-cycle press and release pulses, plus a move_pulse stream with hold-to-repeat behaviour for player-cannon movement and fire.
- One instance per button; outputs feed the game-logic tick domain directly (same clock).

Parameters:
- STABLE_CYCLES, 500000, consecutive cycles btn_sync must differ from btn_level before btn_level flips (5 ms at 100 MHz); must be ≥2.
- REPEAT_DELAY, 30000000, cycles from press pulse to first repeat move_pulse; must be ≥2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat move_pulses; must be ≥2.
- Counter widths are derived internally via $clog2; no width parameters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- btn_sync  input  1  synchronized button level from the upstream synchronizer stage.
- enable  input  1  1 = pulses allowed; 0 = repeat FSM held idle.
- btn_level  output  1  filtered (debounced) button level.
- press_pulse  output  1  one-cycle high on filtered rising edge (when enabled).
- release_pulse  output  1  one-cycle high on filtered falling edge.
- move_pulse  output  1  one-cycle high on press and on each auto-repeat.

Behaviour:
- Reset (rst_n=0 at a rising edge): btn_level=0, press_pulse=0, release_pulse=0, move_pulse=0, stab_cnt=0, rep_cnt=0, FSM=IDLE. Reset dominates every other condition.
- Debounce filter:
  - If btn_sync == btn_level: stab_cnt clears to 0.
  - Otherwise: stab_cnt increments.
  - At the edge where stab_cnt == STABLE_CYCLES-1 and a mismatch is still present: btn_level <= btn_sync and stab_cnt <= 0.
  - Net effect: btn_level changes exactly STABLE_CYCLES cycles after btn_sync settles. Any glitch shorter than STABLE_CYCLES restarts the count and produces no output change.
- Edge pulses: all outputs are registered. press_pulse/release_pulse are high in the same cycle btn_level first shows its new value, for exactly one cycle. release_pulse ignores enable.
- FSM states:
  - IDLE: waits for press.
  - DELAY: counting the initial repeat delay.
  - REPEAT: periodic auto-repeat.
- Transitions:
  - IDLE → DELAY: on the filtered rise with enable=1. press_pulse=1, move_pulse=1, rep_cnt=0.
  - DELAY: rep_cnt increments each cycle. At rep_cnt == REPEAT_DELAY-1 → move_pulse next cycle, go to REPEAT, rep_cnt=0.
  - REPEAT: rep_cnt increments. At rep_cnt == REPEAT_PERIOD-1 → move_pulse next cycle, rep_cnt=0, stay in REPEAT.
  - Any state, filtered fall → IDLE: release_pulse=1, rep_cnt=0. No move_pulse that cycle, even if the terminal count coincides (release wins).
- Timing: if btn_level rises in cycle P, move_pulse is high at P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, then every REPEAT_PERIOD after.
- enable=0:
  - FSM forced to IDLE with rep_cnt=0.
  - press_pulse and move_pulse held 0.
  - Debounce filter and release_pulse keep operating.
- enable rising while the button is held: no pulses. The FSM stays in IDLE until the next filtered rise (a fresh press is required).
- Reset while held: after reset deasserts with btn_sync=1, btn_level rises after STABLE_CYCLES and is treated as a new press.
- Counters never exceed their terminal values; no wrap-around is possible.

Test Plan:
(Parameters STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.)
- Glitch rejection: btn_sync high for 3 cycles then low → btn_level stays 0; no pulses of any kind.
- Clean press: btn_sync rises at cycle 0 and holds → btn_level=1 and press_pulse=move_pulse=1 at cycle 4 only; press_pulse low thereafter.
- Hold-repeat: continue holding to cycle 40 → move_pulse exactly at cycles 4, 14, 19, 24, 29, 34, 39.
- Release on boundary: btn_sync falls so that btn_level falls in the cycle a repeat would fire → release_pulse=1, move_pulse=0, FSM back in IDLE; next press restarts at DELAY.
- Enable masking: enable=0 during a press → btn_level follows, no press/move pulses, release_pulse still fires. Enable raised mid-hold → no move_pulse until release and re-press.
- Reset mid-repeat: rst_n=0 for 1 cycle while in REPEAT with btn_sync=1 → all outputs 0 next cycle; btn_level and press_pulse return 4 cycles after rst_n=1.
